// File: rtl/phase_memory_sequencer_pkg.sv
// Shared encodings for the phase/memory sequencer: one-hot phases, load/store opcodes, control states.
package phase_memory_sequencer_pkg;

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH1     = 5'b00001;
    localparam logic [4:0] PH2     = 5'b00010;
    localparam logic [4:0] PH3     = 5'b00100;
    localparam logic [4:0] PH4     = 5'b01000;
    localparam logic [4:0] PH5     = 5'b10000;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

    function automatic logic [1:0] opcode(input logic [15:0] ir);
        return ir[15:14];
    endfunction

endpackage

// File: rtl/phase_memory_sequencer_if.sv
// External loader/debug port: valid/ready request, one-cycle ack with read data.
interface phase_memory_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  extValid;
    logic [ADDR_WIDTH-1:0] extAddress;
    logic [DATA_WIDTH-1:0] extData;
    logic                  extWrite;
    logic                  extReady;
    logic                  extAck;
    logic [DATA_WIDTH-1:0] extRdata;

    modport master (
        output extValid, extAddress, extData, extWrite,
        input  extReady, extAck, extRdata
    );

    modport slave (
        input  extValid, extAddress, extData, extWrite,
        output extReady, extAck, extRdata
    );
endinterface

// File: rtl/phase_memory_sequencer_ring.sv
// One-hot P1..P5 rotator; park forces all-zero, start loads P1, advance rotates.
// Latency: one clock per control; no backpressure.
module phase_ring
    import phase_memory_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       advance,
    input  logic       park,
    input  logic       start,
    output logic [4:0] phase
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase <= PH_NONE;
        end else if (park) begin
            phase <= PH_NONE;
        end else if (start) begin
            phase <= PH1;
        end else if (advance) begin
            phase <= {phase[3:0], phase[4]};
        end
    end

endmodule

// File: rtl/phase_memory_sequencer.sv
// Phase generator and single-port memory arbiter: CPU owns P1 fetch and P4 load/store, external port gets the rest.
// Latency: memory access issued combinationally in the slot; extAck/extRdata one cycle after accept.
// Backpressure: extReady low only in CPU slots and BOOT; the CPU never stalls.
module phase_memory_sequencer
    import phase_memory_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int START_HALTED = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  haltReq,
    input  logic                  step,
    input  logic [15:0]           IRData,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic [ADDR_WIDTH-1:0] DR,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] memQ,
    phase_memory_sequencer_if.slave ext,
    output logic [4:0]            phase,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memData,
    output logic                  memWren,
    output logic                  halted
);

    seq_state_t state_q, state_d;
    logic       drain_q, drain_d;
    logic       ring_adv, ring_park, ring_start;
    logic       ack_q;
    logic       ext_ready;

    phase_ring u_ring (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (ring_adv),
        .park    (ring_park),
        .start   (ring_start),
        .phase   (phase)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            drain_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            ack_q   <= ext.extValid & ext_ready;
        end
    end

    // A halt request seen on the closing P5 itself still parks at this boundary.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        ring_adv   = 1'b0;
        ring_park  = 1'b0;
        ring_start = 1'b0;
        case (state_q)
            BOOT: begin
                if (START_HALTED != 0) begin
                    state_d   = HALTED;
                    ring_park = 1'b1;
                end else begin
                    state_d    = RUN;
                    ring_start = 1'b1;
                end
            end
            RUN: begin
                drain_d  = drain_q | haltReq;
                ring_adv = 1'b1;
                if (phase == PH5 && (drain_q | haltReq)) begin
                    state_d   = HALTED;
                    drain_d   = 1'b0;
                    ring_park = 1'b1;
                end
            end
            STEP: begin
                ring_adv = 1'b1;
                if (phase == PH5) begin
                    state_d   = HALTED;
                    ring_park = 1'b1;
                end
            end
            HALTED: begin
                drain_d = 1'b0;
                if (!haltReq) begin
                    state_d    = RUN;
                    ring_start = 1'b1;
                end else if (step) begin
                    state_d    = STEP;
                    ring_start = 1'b1;
                end
            end
            default: begin
                state_d   = BOOT;
                ring_park = 1'b1;
            end
        endcase
    end

    logic [1:0] op;
    logic       cpu_fetch, cpu_ldst, cpu_store;

    assign op        = opcode(IRData);
    assign cpu_fetch = (phase == PH1);
    assign cpu_ldst  = (phase == PH4) && (op == OP_LOAD || op == OP_STORE);
    assign cpu_store = (phase == PH4) && (op == OP_STORE);

    always_comb begin
        memAddress = '0;
        memData    = '0;
        memWren    = 1'b0;
        ext_ready  = 1'b0;
        if (cpu_fetch) begin
            memAddress = PC;
        end else if (cpu_ldst) begin
            memAddress = DR;
            if (cpu_store) begin
                memWren = 1'b1;
                memData = writeData;
            end
        end else if (state_q != BOOT) begin
            ext_ready  = 1'b1;
            memAddress = ext.extAddress;
            memWren    = ext.extWrite & ext.extValid;
            if (ext.extWrite & ext.extValid) begin
                memData = ext.extData;
            end
        end
    end

    assign ext.extReady = ext_ready;
    assign ext.extAck   = ack_q;
    assign ext.extRdata = ack_q ? memQ : '0;
    assign halted       = (state_q == HALTED);

endmodule

// File: doc/phase_memory_sequencer.md
Name: phase_memory_sequencer

Overview:
- Generates the CPU's 5-bit one-hot phase and owns the single synchronous-read memory port.
- Multiplexes the memory between CPU fetch (P1), CPU load/store (P4) and an external loader/debug port that uses a valid/ready handshake.
- Provides halt, drain and single-step control so the loader can write program memory while the CPU is parked.
- Sits between the phase consumers (register file, ALU, IR latch) and the Memory macro.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 16, memory word width.
- START_HALTED, 0, if 1 the block leaves reset in HALTED, otherwise in RUN.

Ports:
- clock  in  1  system clock; memory samples address/data/wren on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- haltReq  in  1  level; request to park the CPU at an instruction boundary.
- step  in  1  one-cycle pulse; execute exactly one instruction while HALTED.
- IRData  in  16  current instruction; [15:14] 00 = load, 01 = store.
- PC  in  ADDR_WIDTH  fetch address.
- DR  in  ADDR_WIDTH  load/store address.
- writeData  in  DATA_WIDTH  store data.
- memQ  in  DATA_WIDTH  memory read data, valid the cycle after the address is sampled.
- extValid  in  1  external request valid.
- extAddress  in  ADDR_WIDTH  external address.
- extData  in  DATA_WIDTH  external write data.
- extWrite  in  1  1 = write, 0 = read.
- phase  out  5  one-hot phase P1..P5 = 00001..10000; 00000 = parked.
- memAddress  out  ADDR_WIDTH  to Memory.address.
- memData  out  DATA_WIDTH  to Memory.data.
- memWren  out  1  to Memory.wren.
- extReady  out  1  external request accepted this cycle when extValid is also high.
- extAck  out  1  one-cycle pulse, the cycle after acceptance.
- extRdata  out  DATA_WIDTH  equals memQ while extAck is high; 0 otherwise.
- halted  out  1  high while in HALTED.

Behaviour:
- Reset (asynchronous): phase=00000, state=BOOT, extAck=0, halted=0, drain flag=0. memWren, extReady and memAddress are forced 0 while in BOOT.
- BOOT: on the first clock after reset is released, goes to RUN with phase=P1, or to HALTED with phase=00000 if START_HALTED=1.
- RUN:
  - phase rotates P1→P2→P3→P4→P5 one step per clock.
  - Any cycle with haltReq=1 sets the drain flag.
  - At P5: if the drain flag is set → HALTED, phase=00000, flag cleared; otherwise → P1.
  - haltReq never truncates an instruction.
- HALTED:
  - halted=1, phase=00000, extReady=1 every cycle.
  - haltReq=0 → RUN at P1 on the next cycle.
  - Else step=1 → STEP at P1 on the next cycle.
  - haltReq=0 together with step=1 → RUN; the step is ignored.
- STEP: identical to RUN, but at P5 it always returns to HALTED. haltReq and step are ignored during STEP.
- CPU slot:
  - phase==P1 → address=PC, wren=0.
  - phase==P4 and IR[15:14]==00 → address=DR, wren=0.
  - phase==P4 and IR[15:14]==01 → address=DR, data=writeData, wren=1.
- External slot:
  - Any running cycle (not BOOT) where the CPU slot is inactive: extReady=1, address=extAddress, data=extData, wren=extWrite&extValid.
  - CPU slot active → extReady=0. The CPU always wins; no CPU stall ever.
  - In RUN, P2, P3, P5 and non-memory P4 are free for the external port.
- Handshake:
  - Accepted when extValid&extReady at a rising edge.
  - extAck pulses on the next cycle; extRdata=memQ for reads and is undefined for writes.
  - The requester holds extAddress, extData and extWrite stable until accepted.
  - Back-to-back accepts are allowed: one per free cycle.
- memQ ownership: the cycle after an external accept belongs to extRdata; all other cycles belong to the CPU. The two never overlap because at most one access is issued per cycle.
- Unused outputs: memData=0 when wren=0 and no external write is in progress; memAddress=0 in BOOT.
- Reset mid-operation: all state is abandoned and the block returns to BOOT. A pending extAck is lost, and the requester must reissue.

Decomposition:
- Shared package holds:
  - phase encodings PH_NONE, PH1..PH5;
  - opcode field constants OP_LOAD=2'b00, OP_STORE=2'b01;
  - the state enum BOOT/RUN/STEP/HALTED.
- One natural sub-module, phase_ring: the one-hot rotator with advance/park/start controls. The memory mux and handshake logic stay in the top module.

Test Plan:
- Reset release, START_HALTED=0 → phase sequence 00001,00010,00100,01000,10000,00001; memWren=0 throughout with IR=16'h8000.
- IR=16'h4000, DR=16'h0020, writeData=16'hBEEF → at P4: memAddress=0x0020, memWren=1, memData=0xBEEF, extReady=0; readback of 0x0020 via the external port returns 0xBEEF.
- haltReq asserted at P2 → P3, P4, P5 complete, then phase=00000 and halted=1; external writes of 0x1234 to addresses 0..3 in 4 consecutive cycles → 4 extAck pulses, one cycle after each accept.
- While HALTED, pulse step with haltReq=1 → exactly one P1..P5 pass with a fetch from PC, then halted=1 again; a second step gives one more pass.
- In RUN with extValid held and a read of 0x0010 (preloaded 0x5A5A) issued at P1 → extReady stays 0 at P1, goes 1 at P2; extAck at P3 with extRdata=0x5A5A.
- Drive reset_n low during STEP at P4 with a store pending → memWren drops immediately (asynchronously), phase=00000; after release, state follows START_HALTED.
